// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execution unit. It takes the two register
//   file read values and a destination index, and returns the result, index
//   and write enable that drive the register file write port.
//
//   Multiply is shift-add, one multiplier bit per cycle, and forms the full
//   2*XLEN product. Divide is restoring shift-subtract, one quotient bit per
//   cycle. Signed operands are converted to magnitudes first, and the sign is
//   fixed up afterwards.
//
//   Divide-by-zero and signed overflow finish in a single cycle at acceptance.
//
//   Optional feature (macro MULDIV_REUSE_EN):
//     The unit keeps both halves of the last completed operation. A new op
//     with the same operands and the same class completes in one cycle, using
//     the stored value. Examples are MULH followed by MUL, and DIV followed by
//     REM.
//
// Parameters
//   XLEN   operand/result width (even, >= 8)
//   CNT_W  iteration counter width (2**CNT_W > XLEN)
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_start      request, accepted only while idle
//   i_op         funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   i_rs1_val    operand A
//   i_rs2_val    operand B
//   i_rd_in      destination register index
//   i_kill       abort the in-flight op
//   o_busy       op in progress
//   o_done       one-cycle completion pulse
//   o_result     result, held until the next done
//   o_rd_out     destination index, held with the result
//   o_wb_en      done and rd_out != 0
//
// States
//   S_IDLE | waiting for start; fast-path ops complete here
//   S_PREP | latch signs, take magnitudes, clear accumulator
//   S_CALC | one iteration per cycle; the last cycle also does the sign fix
//          | and output select, so the done cycle is already back in S_IDLE
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [4:0]      i_rd_in,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_out,
    output logic            o_wb_en
);

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC
    } state_t;

    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM. MUL is grouped with MULH so
    // that both share one stored product.
    function automatic logic f_a_signed(input logic [2:0] op);
        return op[2] ? ~op[0] : (op != 3'd3);
    endfunction

    function automatic logic f_b_signed(input logic [2:0] op);
        return op[2] ? ~op[0] : ~op[1];
    endfunction

    // High half means the upper product word for MULH*, and the remainder for
    // REM/REMU.
    function automatic logic f_sel_hi(input logic [2:0] op);
        return op[2] ? op[1] : (op[1:0] != 2'b00);
    endfunction

    function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] x,
                                              input logic            s);
        return (s && x[XLEN-1]) ? -x : x;
    endfunction

    state_t            r_state;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_m;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;
    logic              r_wb_en;

    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_val;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_val;

    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_hi_nx;
    logic [XLEN-1:0]   w_lo_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_lo_res;
    logic [XLEN-1:0]   w_hi_res;
    logic [XLEN-1:0]   w_res;

    // Special cases are decided from the live inputs in the acceptance cycle.
    always_comb begin
        w_div_zero = i_op[2] && (i_rs2_val == '0);
        w_ovf      = i_op[2] && !i_op[0] && (i_rs1_val == MIN_NEG) && (i_rs2_val == '1);
        w_special  = w_div_zero || w_ovf;
        if (w_div_zero) begin
            w_fast_val = i_op[1] ? i_rs1_val : '1;
        end else if (w_ovf) begin
            w_fast_val = i_op[1] ? '0 : MIN_NEG;
        end else begin
            w_fast_val = w_hit_val;
        end
        w_fast = w_special || w_hit;
    end

    always_comb begin
        w_sa    = f_a_signed(r_op) && r_a[XLEN-1];
        w_sb    = f_b_signed(r_op) && r_b[XLEN-1];
        w_abs_a = f_abs(r_a, f_a_signed(r_op));
        w_abs_b = f_abs(r_b, f_b_signed(r_op));
    end

    // One iteration step. For a multiply, r_lo holds the multiplier, which
    // shifts out as the product shifts in. For a divide, r_lo holds the
    // dividend, which shifts out as the quotient shifts in, and r_hi holds the
    // partial remainder.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_m};
        if (r_op[2]) begin
            if (!w_diff[XLEN]) begin
                w_hi_nx = w_diff[XLEN-1:0];
                w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nx = w_shift[XLEN-1:0];
                w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_hi_nx = w_sum[XLEN:1];
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end

        w_prod   = {w_hi_nx, w_lo_nx};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_quo_s  = r_neg_q ? -w_lo_nx : w_lo_nx;
        w_rem_s  = r_neg_r ? -w_hi_nx : w_hi_nx;
        w_lo_res = r_op[2] ? w_quo_s : w_prod_s[XLEN-1:0];
        w_hi_res = r_op[2] ? w_rem_s : w_prod_s[2*XLEN-1:XLEN];
        w_res    = f_sel_hi(r_op) ? w_hi_res : w_lo_res;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wb_en  <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_done  <= 1'b0;
            r_wb_en <= 1'b0;
            if (r_state != S_IDLE && i_kill) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !i_kill) begin
                            r_op <= i_op;
                            r_a  <= i_rs1_val;
                            r_b  <= i_rs2_val;
                            r_rd <= i_rd_in;
                            if (w_fast) begin
                                r_done   <= 1'b1;
                                r_result <= w_fast_val;
                                r_rd_out <= i_rd_in;
                                r_wb_en  <= (i_rd_in != 5'd0);
                            end else begin
                                r_state <= S_PREP;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    S_PREP: begin
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_hi    <= '0;
                        if (r_op[2]) begin
                            r_lo <= w_abs_a;
                            r_m  <= w_abs_b;
                        end else begin
                            r_lo <= w_abs_b;
                            r_m  <= w_abs_a;
                        end
                        r_cnt   <= CNT_LAST;
                        r_state <= S_CALC;
                    end
                    S_CALC: begin
                        r_hi <= w_hi_nx;
                        r_lo <= w_lo_nx;
                        if (r_cnt == '0) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_res;
                            r_rd_out <= r_rd;
                            r_wb_en  <= (r_rd != 5'd0);
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MULDIV_REUSE_EN
    logic            r_rv_valid;
    logic [XLEN-1:0] r_rv_a;
    logic [XLEN-1:0] r_rv_b;
    logic [2:0]      r_rv_cls;
    logic [XLEN-1:0] r_rv_lo;
    logic [XLEN-1:0] r_rv_hi;
    logic [2:0]      w_cls;
    logic            w_fin;

    // Class is {div, rs1 signed, rs2 signed}. Ops in the same class produce
    // the same pair of halves.
    assign w_cls     = {i_op[2], f_a_signed(i_op), f_b_signed(i_op)};
    assign w_hit     = r_rv_valid && (i_rs1_val == r_rv_a) && (i_rs2_val == r_rv_b)
                       && (w_cls == r_rv_cls);
    assign w_hit_val = f_sel_hi(i_op) ? r_rv_hi : r_rv_lo;
    assign w_fin     = (r_state == S_CALC) && (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rv_valid <= 1'b0;
        end else if (r_state != S_IDLE && i_kill) begin
            r_rv_valid <= 1'b0;
        end else if (r_state == S_IDLE && i_start && !i_kill && w_special) begin
            r_rv_valid <= 1'b0;
        end else if (w_fin) begin
            r_rv_valid <= 1'b1;
            r_rv_a     <= r_a;
            r_rv_b     <= r_b;
            r_rv_cls   <= {r_op[2], f_a_signed(r_op), f_b_signed(r_op)};
            r_rv_lo    <= w_lo_res;
            r_rv_hi    <= w_hi_res;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_val = '0;
`endif

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_rd_out = r_rd_out;
    assign o_wb_en  = r_wb_en;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed vectors for muldiv_unit with hand-computed results and latencies.
//   Latency counts from the acceptance edge: fast-path ops see done right
//   after that edge (1), and iterative ops see it XLEN+2 cycles later.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int NL   = XLEN + 2;
`ifdef MULDIV_REUSE_EN
    localparam int RL   = 1;
`else
    localparam int RL   = XLEN + 2;
`endif

    logic            clk = 1'b0;
    logic            i_rst;
    logic            i_start;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_rs1_val;
    logic [XLEN-1:0] i_rs2_val;
    logic [4:0]      i_rd_in;
    logic            i_kill;
    logic            o_busy;
    logic            o_done;
    logic [XLEN-1:0] o_result;
    logic [4:0]      o_rd_out;
    logic            o_wb_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_op      (i_op),
        .i_rs1_val (i_rs1_val),
        .i_rs2_val (i_rs2_val),
        .i_rd_in   (i_rd_in),
        .i_kill    (i_kill),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_result  (o_result),
        .o_rd_out  (o_rd_out),
        .o_wb_en   (o_wb_en)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called between edges. Drives one request, scrambles the operands after
    // acceptance, and returns in the done cycle, so that consecutive calls
    // are back-to-back.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res,
                          input int exp_lat);
        int lat;
        int bsy;
        i_start   = 1'b1;
        i_op      = op;
        i_rs1_val = a;
        i_rs2_val = b;
        i_rd_in   = rd;
        @(posedge clk); #1;
        i_start   = 1'b0;
        i_op      = op ^ 3'd5;
        i_rs1_val = ~a;
        i_rs2_val = a ^ b ^ 32'h5a5a_5a5a;
        i_rd_in   = ~rd;
        lat = 1;
        bsy = 0;
        while (!o_done && lat < 200) begin
            if (o_busy) bsy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"},   64'(lat), 64'(exp_lat));
        chk({tag, ".busy"},  64'(bsy), 64'(exp_lat - 1));
        chk({tag, ".res"},   64'(o_result), 64'(exp_res));
        chk({tag, ".rd"},    64'(o_rd_out), 64'(rd));
        chk({tag, ".wb_en"}, 64'(o_wb_en), 64'(rd != 5'd0));
        chk({tag, ".busy_at_done"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_op      = 3'd0;
        i_rs1_val = '0;
        i_rs2_val = '0;
        i_rd_in   = 5'd0;
        i_kill    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy",   64'(o_busy),   64'd0);
        chk("rst.done",   64'(o_done),   64'd0);
        chk("rst.wb_en",  64'(o_wb_en),  64'd0);
        chk("rst.result", 64'(o_result), 64'd0);
        chk("rst.rd_out", 64'(o_rd_out), 64'd0);
        i_rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        run_op("mul_7xm3",      3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, NL);
        run_op("mulhu_ff",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, NL);
        run_op("mulh_ff",       3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, NL);
        run_op("mulhsu_ff",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, NL);
        run_op("mul_m1xm1",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, NL);
        run_op("mulh_after_mul",3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, RL);
        run_op("div_m20_3",     3'd4, 32'hFFFF_FFEC, 32'd3,         5'd6, 32'hFFFF_FFFA, NL);
        run_op("rem_m20_3",     3'd6, 32'hFFFF_FFEC, 32'd3,         5'd6, 32'hFFFF_FFFE, RL);
        run_op("divu_100_7",    3'd5, 32'd100,       32'd7,         5'd7, 32'd14,        NL);
        run_op("remu_100_7",    3'd7, 32'd100,       32'd7,         5'd7, 32'd2,         RL);
        run_op("divu_by0",      3'd5, 32'd5,         32'd0,         5'd8, 32'hFFFF_FFFF, 1);
        run_op("rem_by0",       3'd6, 32'd5,         32'd0,         5'd8, 32'd5,         1);
        run_op("div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1);
        run_op("rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0,         1);
        run_op("div_100_7",     3'd4, 32'd100,       32'd7,         5'd9, 32'd14,        NL);
        run_op("rem_100_7",     3'd6, 32'd100,       32'd7,         5'd9, 32'd2,         RL);
        run_op("div_7_m2",      3'd4, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, NL);
        run_op("rem_7_m2",      3'd6, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'd1,        RL);
        run_op("mul_rd0",       3'd0, 32'd3,         32'd4,         5'd0, 32'd12,        NL);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(o_done), 64'd0);

        // kill part-way through a divide
        i_start = 1'b1; i_op = 3'd4; i_rs1_val = 32'd1000; i_rs2_val = 32'd3; i_rd_in = 5'd9;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("kill.busy_before", 64'(o_busy), 64'd1);
        i_kill = 1'b1;
        @(posedge clk); #1;
        i_kill = 1'b0;
        chk("kill.busy", 64'(o_busy), 64'd0);
        chk("kill.done", 64'(o_done), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_done) ndone++;
        end
        chk("kill.no_done", 64'(ndone),    64'd0);
        chk("kill.result",  64'(o_result), 64'd12);
        chk("kill.rd_out",  64'(o_rd_out), 64'd0);
        run_op("div_after_kill", 3'd4, 32'd1000, 32'd3, 5'd9, 32'd333, NL);
        run_op("rem_after_div",  3'd6, 32'd1000, 32'd3, 5'd9, 32'd1,   RL);

        // start together with kill while idle must be ignored
        @(posedge clk); #1;
        i_start = 1'b1; i_kill = 1'b1; i_op = 3'd5; i_rs1_val = 32'd9; i_rs2_val = 32'd0; i_rd_in = 5'd3;
        @(posedge clk); #1;
        i_start = 1'b0; i_kill = 1'b0;
        chk("kill_start.busy",   64'(o_busy),   64'd0);
        chk("kill_start.done",   64'(o_done),   64'd0);
        chk("kill_start.result", 64'(o_result), 64'd1);

        // reset in the middle of CALC
        i_start = 1'b1; i_op = 3'd0; i_rs1_val = 32'd5; i_rs2_val = 32'd6; i_rd_in = 5'd3;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        chk("midrst.busy",   64'(o_busy),   64'd0);
        chk("midrst.done",   64'(o_done),   64'd0);
        chk("midrst.result", 64'(o_result), 64'd0);
        chk("midrst.rd_out", 64'(o_rd_out), 64'd0);
        chk("midrst.wb_en",  64'(o_wb_en),  64'd0);
        run_op("rem_after_rst", 3'd6, 32'd1000, 32'd3, 5'd4, 32'd1, NL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the integer register file: consumes the two read-port values (rs1/rs2) and the destination index.
- Returns a result, destination index and write-enable that drive the register file's write port (WD3/A3/WE3).
- Occupies the core for tens of cycles per operation; the core stalls on busy.

Parameters:
- XLEN, 32, operand/result width; must be even, ≥8.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_val  in  XLEN  operand A (register file read port 1)
- rs2_val  in  XLEN  operand B (register file read port 2)
- rd_in  in  5  destination register index
- kill  in  1  synchronous abort of the in-flight op (pipeline flush)
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle completion pulse
- result  out  XLEN  result; held stable until the next done
- rd_out  out  5  destination index of result; held with result
- wb_en  out  1  done & (rd_out != 0); drives register file write enable

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, wb_en=0, result=0, rd_out=0. Reset overrides start and kill, including mid-operation.
- Acceptance: start=1 and state=IDLE at edge k. Latch op, operands and rd_in; busy=1 from cycle k+1. start while busy is ignored (no queueing).
- States:
  - IDLE
  - PREP: record operand signs per op; take absolute values for signed operands; clear accumulator.
  - CALC: XLEN iterations, one bit per cycle. Multiply is shift-add, forming a 2*XLEN product. Divide is restoring shift-subtract, forming quotient and remainder.
  - FIN: apply sign correction (two's complement negate); select output; pulse done; return to IDLE.
- Normal latency: done high in cycle k+XLEN+2 (PREP 1 + CALC XLEN + FIN 1). busy drops in the same cycle done rises.
- Output selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Sign rules:
  - MULH: both operands signed; product negative iff signs differ.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV: quotient negative iff signs differ.
  - REM: remainder takes the sign of the dividend.
- Fast path: detected at acceptance; bypasses PREP/CALC; done high in cycle k+1.
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give rs1_val.
  - Signed overflow: DIV with rs1 = -2^(XLEN-1) and rs2 = -1 gives -2^(XLEN-1); REM in the same case gives 0.
- Back-to-back: start may be asserted in the done cycle. The unit is in IDLE, so the new op is accepted at that edge.
- kill=1 at any edge while busy: return to IDLE; busy=0 next cycle; no done. result and rd_out keep their previous values. kill in IDLE has no effect. kill together with start in IDLE: start is ignored.
- rd_in=0: computed normally; done pulses; wb_en stays 0.
- Operand inputs are sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro MULDIV_REUSE_EN.
- Defined: keep the last completed (rs1_val, rs2_val, signedness class, mul/div class) and both halves of the product, or both quotient and remainder.
  - A new op whose operands and class match the kept entry completes on the fast path (done in k+1), returning the other half from storage. Example: MULH then MUL, or DIV then REM.
  - The stored entry is invalidated on rst, on kill, and on any fast-path div-by-zero or overflow op.
- Undefined: no storage; every non-special op takes XLEN+2 cycles.

Test Plan:
- MUL 7 × -3, rd_in=5, start at cycle 10 → busy cycles 11–43; done=1, wb_en=1, result=0xFFFFFFEB, rd_out=5 at cycle 44.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE after 34 cycles. MULH with the same operands → 0x00000000. MULHSU(-1, 0xFFFFFFFF) → 0xFFFFFFFF.
- DIV -20 / 3 → 0xFFFFFFFA (-6). REM -20 / 3 → 0xFFFFFFFE (-2). DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → done next cycle with 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, done next cycle.
- kill at cycle 15 of a DIV → busy=0 at cycle 16; no done; result holds its prior value. start asserted in a done cycle → accepted; second done arrives 34 cycles later. rd_in=0 → done=1, wb_en=0.
- rst asserted mid-CALC → next cycle busy=0, done=0, result=0. With MULDIV_REUSE_EN: DIV 100 / 7 then REM 100 / 7 → second done 1 cycle after acceptance with result 2.
